// File: rtl/flip_alpha_gen_pkg.sv
// Shared definitions for the Chase flip-alpha generator: code encodings, frame limits,
// primitive polynomials, FSM encoding and the single-step multiply-by-alpha helper.
package flip_alpha_gen_pkg;

   localparam int AW = 10;

   localparam logic [1:0] CODE_63   = 2'b00;
   localparam logic [1:0] CODE_255  = 2'b01;
   localparam logic [1:0] CODE_1023 = 2'b10;

   localparam logic [AW-1:0] LAST_63   = 10'd62;
   localparam logic [AW-1:0] LAST_255  = 10'd254;
   localparam logic [AW-1:0] LAST_1023 = 10'd1022;

   localparam logic [AW:0] POLY_63   = 11'h043;
   localparam logic [AW:0] POLY_255  = 11'h11D;
   localparam logic [AW:0] POLY_1023 = 11'h409;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   typedef struct packed {
      logic [AW-1:0] a1;
      logic [AW-1:0] a3;
      logic [AW-1:0] a5;
      logic [AW-1:0] a7;
   } alpha_set_t;

   function automatic logic [AW-1:0] last_pos(input logic [1:0] code);
      logic [AW-1:0] lim;
      case (code)
         CODE_63:  lim = LAST_63;
         CODE_255: lim = LAST_255;
         default:  lim = LAST_1023;
      endcase
      return lim;
   endfunction

   // Shift left and fold the overflow bit back through the primitive polynomial.
   function automatic logic [AW-1:0] mul_alpha(input logic [AW-1:0] x, input logic [1:0] code);
      logic [AW:0]   sh;
      logic [AW-1:0] y;
      sh = {x, 1'b0};
      case (code)
         CODE_63: begin
            if (sh[6]) sh = sh ^ POLY_63;
            y = {4'b0, sh[5:0]};
         end
         CODE_255: begin
            if (sh[8]) sh = sh ^ POLY_255;
            y = {2'b0, sh[7:0]};
         end
         default: begin
            if (sh[10]) sh = sh ^ POLY_1023;
            y = sh[9:0];
         end
      endcase
      return y;
   endfunction

endpackage

// File: rtl/flip_alpha_gen_mult.sv
// gf_mult_alpha_pow: combinational multiply by alpha^K in the field chosen by i_code.
import flip_alpha_gen_pkg::*;

module gf_mult_alpha_pow #(
   parameter int K = 1
) (
   input  logic [AW-1:0] i_x,
   input  logic [1:0]    i_code,
   output logic [AW-1:0] o_y
);

   always_comb begin
      o_y = i_x;
      for (int i = 0; i < K; i++) begin
         o_y = mul_alpha(o_y, i_code);
      end
   end

endmodule

// File: rtl/flip_alpha_gen.sv
// flip_alpha_gen: finds the two least-reliable positions of a frame and emits alpha^(k*p), k=1,3,5,7.
// Optional macro FLIP_POS_OUT_EN adds the captured positions as o_pos1/o_pos2.
import flip_alpha_gen_pkg::*;

module flip_alpha_gen #(
   parameter int RW = 7
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic [1:0]    i_code,
   input  logic          i_start,
   input  logic          i_valid,
   input  logic [RW-1:0] i_rel,
   output logic [AW-1:0] o_flip_alpha_S1_1,
   output logic [AW-1:0] o_flip_alpha_S3_1,
   output logic [AW-1:0] o_flip_alpha_S5_1,
   output logic [AW-1:0] o_flip_alpha_S7_1,
   output logic [AW-1:0] o_flip_alpha_S1_2,
   output logic [AW-1:0] o_flip_alpha_S3_2,
   output logic [AW-1:0] o_flip_alpha_S5_2,
   output logic [AW-1:0] o_flip_alpha_S7_2,
   output logic          o_flip_alpha_valid,
`ifdef FLIP_POS_OUT_EN
   output logic [AW-1:0] o_pos1,
   output logic [AW-1:0] o_pos2,
`endif
   output logic          o_busy
);

   localparam logic [RW:0] REL_SENTINEL = {1'b1, {RW{1'b0}}};
   localparam alpha_set_t  X_ONE        = '{a1: AW'(1), a3: AW'(1), a5: AW'(1), a7: AW'(1)};

   state_e        state_q, state_d;
   logic [1:0]    code_q, code_d;
   logic [AW-1:0] cnt_q, cnt_d;
   alpha_set_t    x_q, x_d;
   logic [RW:0]   min1_q, min1_d, min2_q, min2_d;
   alpha_set_t    slot1_q, slot1_d, slot2_q, slot2_d;
`ifdef FLIP_POS_OUT_EN
   logic [AW-1:0] pos1_q, pos1_d, pos2_q, pos2_d;
`endif

   logic [1:0]    code_cur;
   logic [AW-1:0] cnt_cur;
   alpha_set_t    x_cur;
   logic [RW:0]   min1_cur, min2_cur;
   logic [AW-1:0] mul_y1, mul_y3, mul_y5, mul_y7;
   logic          beat_acc;
   logic [RW:0]   rel_ext;

   // A start cycle behaves as if the frame state were already re-initialised, so a
   // beat arriving together with i_start is handled as position 0 of the new frame.
   always_comb begin
      code_cur = code_q;
      cnt_cur  = cnt_q;
      x_cur    = x_q;
      min1_cur = min1_q;
      min2_cur = min2_q;
      if (i_start) begin
         code_cur = i_code;
         cnt_cur  = '0;
         x_cur    = X_ONE;
         min1_cur = REL_SENTINEL;
         min2_cur = REL_SENTINEL;
      end
   end

   assign beat_acc = i_valid && (i_start || (state_q == ST_SCAN));
   assign rel_ext  = {1'b0, i_rel};

   gf_mult_alpha_pow #(.K(1)) u_mul1 (.i_x(x_cur.a1), .i_code(code_cur), .o_y(mul_y1));
   gf_mult_alpha_pow #(.K(3)) u_mul3 (.i_x(x_cur.a3), .i_code(code_cur), .o_y(mul_y3));
   gf_mult_alpha_pow #(.K(5)) u_mul5 (.i_x(x_cur.a5), .i_code(code_cur), .o_y(mul_y5));
   gf_mult_alpha_pow #(.K(7)) u_mul7 (.i_x(x_cur.a7), .i_code(code_cur), .o_y(mul_y7));

   always_comb begin
      state_d = state_q;
      code_d  = code_cur;
      cnt_d   = cnt_cur;
      x_d     = x_cur;
      min1_d  = min1_cur;
      min2_d  = min2_cur;
      slot1_d = slot1_q;
      slot2_d = slot2_q;
`ifdef FLIP_POS_OUT_EN
      pos1_d  = pos1_q;
      pos2_d  = pos2_q;
`endif
      if (i_start) begin
         state_d = ST_SCAN;
      end
      if (beat_acc) begin
         // Strict compares keep the earlier position on equal reliability.
         if (rel_ext < min1_cur) begin
            min2_d  = min1_cur;
            slot2_d = slot1_q;
            min1_d  = rel_ext;
            slot1_d = x_cur;
`ifdef FLIP_POS_OUT_EN
            pos2_d  = pos1_q;
            pos1_d  = cnt_cur;
`endif
         end else if (rel_ext < min2_cur) begin
            min2_d  = rel_ext;
            slot2_d = x_cur;
`ifdef FLIP_POS_OUT_EN
            pos2_d  = cnt_cur;
`endif
         end
         cnt_d = cnt_cur + AW'(1);
         x_d   = '{a1: mul_y1, a3: mul_y3, a5: mul_y5, a7: mul_y7};
         if (cnt_cur == last_pos(code_cur)) begin
            state_d = ST_DONE;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= ST_IDLE;
         code_q  <= '0;
         cnt_q   <= '0;
         x_q     <= '0;
         min1_q  <= REL_SENTINEL;
         min2_q  <= REL_SENTINEL;
         slot1_q <= '0;
         slot2_q <= '0;
`ifdef FLIP_POS_OUT_EN
         pos1_q  <= '0;
         pos2_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         code_q  <= code_d;
         cnt_q   <= cnt_d;
         x_q     <= x_d;
         min1_q  <= min1_d;
         min2_q  <= min2_d;
         slot1_q <= slot1_d;
         slot2_q <= slot2_d;
`ifdef FLIP_POS_OUT_EN
         pos1_q  <= pos1_d;
         pos2_q  <= pos2_d;
`endif
      end
   end

   logic out_en;
   logic hi_en;

   // Results are only presented in DONE; odd powers 5 and 7 exist only for the n=1023 code.
   assign out_en             = (state_q == ST_DONE);
   assign hi_en              = out_en && (code_q == CODE_1023);
   assign o_flip_alpha_valid = out_en;
   assign o_busy             = (state_q == ST_SCAN);

   assign o_flip_alpha_S1_1 = out_en ? slot1_q.a1 : '0;
   assign o_flip_alpha_S3_1 = out_en ? slot1_q.a3 : '0;
   assign o_flip_alpha_S5_1 = hi_en  ? slot1_q.a5 : '0;
   assign o_flip_alpha_S7_1 = hi_en  ? slot1_q.a7 : '0;
   assign o_flip_alpha_S1_2 = out_en ? slot2_q.a1 : '0;
   assign o_flip_alpha_S3_2 = out_en ? slot2_q.a3 : '0;
   assign o_flip_alpha_S5_2 = hi_en  ? slot2_q.a5 : '0;
   assign o_flip_alpha_S7_2 = hi_en  ? slot2_q.a7 : '0;

`ifdef FLIP_POS_OUT_EN
   assign o_pos1 = out_en ? pos1_q : '0;
   assign o_pos2 = out_en ? pos2_q : '0;
`endif

endmodule

// File: tb/tb_flip_alpha_gen.sv
// Self-checking bench for flip_alpha_gen: directed frames with a scoreboard of expected alpha sets.
module tb_flip_alpha_gen;

   localparam int RW = 7;

   typedef struct packed {
      logic [7:0][9:0] a;
      logic [9:0]      p1;
      logic [9:0]      p2;
   } exp_t;

   logic          clk;
   logic          rstN;
   logic [1:0]    iCode;
   logic          iStart;
   logic          iValid;
   logic [RW-1:0] iRel;
   logic [9:0]    s11, s31, s51, s71, s12, s32, s52, s72;
   logic          flipValid;
   logic          busy;
`ifdef FLIP_POS_OUT_EN
   logic [9:0]    pos1, pos2;
`endif

   int   checks   = 0;
   int   failures = 0;
   int   relArr[1023];
   exp_t expQ[$];

   flip_alpha_gen #(.RW(RW)) dut (
      .i_clk             (clk),
      .i_rst_n           (rstN),
      .i_code            (iCode),
      .i_start           (iStart),
      .i_valid           (iValid),
      .i_rel             (iRel),
      .o_flip_alpha_S1_1 (s11),
      .o_flip_alpha_S3_1 (s31),
      .o_flip_alpha_S5_1 (s51),
      .o_flip_alpha_S7_1 (s71),
      .o_flip_alpha_S1_2 (s12),
      .o_flip_alpha_S3_2 (s32),
      .o_flip_alpha_S5_2 (s52),
      .o_flip_alpha_S7_2 (s72),
      .o_flip_alpha_valid(flipValid),
`ifdef FLIP_POS_OUT_EN
      .o_pos1            (pos1),
      .o_pos2            (pos2),
`endif
      .o_busy            (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int frameLen(input logic [1:0] code);
      return (code == 2'b00) ? 63 : (code == 2'b01) ? 255 : 1023;
   endfunction

   // Field arithmetic model: alpha^e by repeated doubling modulo the field polynomial.
   function automatic logic [9:0] alphaPow(input logic [1:0] code, input int e);
      int          m;
      logic [10:0] poly;
      logic [10:0] t;
      logic [9:0]  x;
      m    = (code == 2'b00) ? 6 : (code == 2'b01) ? 8 : 10;
      poly = (code == 2'b00) ? 11'h043 : (code == 2'b01) ? 11'h11D : 11'h409;
      x    = 10'd1;
      for (int i = 0; i < (e % frameLen(code)); i++) begin
         t = {x, 1'b0};
         if (t[m]) t = t ^ poly;
         x = t[9:0];
      end
      return x;
   endfunction

   // Expected result: p1 = first position of the global minimum, p2 = first minimum among the rest.
   task automatic pushExpected(input logic [1:0] code);
      int   n;
      int   p1;
      int   p2;
      int   k;
      exp_t e;
      n  = frameLen(code);
      p1 = 0;
      for (int c = 1; c < n; c++) if (relArr[c] < relArr[p1]) p1 = c;
      p2 = (p1 == 0) ? 1 : 0;
      for (int c = 0; c < n; c++) if (c != p1 && relArr[c] < relArr[p2]) p2 = c;
      for (int j = 0; j < 4; j++) begin
         k = 2 * j + 1;
         e.a[j]     = (j >= 2 && code != 2'b10) ? 10'd0 : alphaPow(code, k * p1);
         e.a[j + 4] = (j >= 2 && code != 2'b10) ? 10'd0 : alphaPow(code, k * p2);
      end
      e.p1 = 10'(p1);
      e.p2 = 10'(p2);
      expQ.push_back(e);
   endtask

   task automatic checkEq(input string tag, input logic [9:0] obs, input logic [9:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("[TB] FAIL %s observed=0x%03h expected=0x%03h", tag, obs, expv);
      end
   endtask

   task automatic checkBit(input string tag, input logic obs, input logic expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, expv);
      end
   endtask

   // Drives one frame; when full=0 the frame is cut after nbeats and left mid-beat.
   task automatic applyStimulus(input logic [1:0] code, input int nbeats, input bit gaps, input bit full);
      int n;
      int c;
      bit gapNow;
      bit firstCycle;
      n = frameLen(code);
      if (full) pushExpected(code);
      @(negedge clk);
      iStart = 1'b1;
      iCode  = code;
      iValid = 1'b1;
      iRel   = RW'(relArr[0]);
      c          = 1;
      gapNow     = gaps;
      firstCycle = 1'b1;
      while (c < nbeats) begin
         @(negedge clk);
         if (firstCycle) begin
            checkBit("valid_low_after_start", flipValid, 1'b0);
            checkBit("busy_after_start", busy, 1'b1);
            firstCycle = 1'b0;
         end
         iStart = 1'b0;
         iCode  = code ^ 2'b10;
         if (gapNow) begin
            iValid = 1'b0;
            iRel   = '0;
         end else begin
            if (c == n - 1) checkBit("valid_low_before_last", flipValid, 1'b0);
            iValid = 1'b1;
            iRel   = RW'(relArr[c]);
            c++;
         end
         if (gaps) gapNow = ~gapNow;
      end
      if (full) begin
         @(negedge clk);
         iValid = 1'b0;
         iCode  = code;
         checkBit("valid_latency", flipValid, 1'b1);
         if (flipValid !== 1'b1) begin
            for (int w = 0; w < 20 && flipValid !== 1'b1; w++) @(negedge clk);
            checkBit("valid_timeout", flipValid, 1'b1);
         end
      end
   endtask

   task automatic checkOutput(input string tag);
      exp_t            e;
      logic [7:0][9:0] obs;
      string           names[8];
      names = '{"S1_1", "S3_1", "S5_1", "S7_1", "S1_2", "S3_2", "S5_2", "S7_2"};
      checks++;
      assert (expQ.size() > 0) else begin
         failures++;
         $error("[TB] FAIL %s_scoreboard observed=empty expected=entry", tag);
      end
      if (expQ.size() > 0) begin
         e = expQ.pop_front();
         obs[0] = s11; obs[1] = s31; obs[2] = s51; obs[3] = s71;
         obs[4] = s12; obs[5] = s32; obs[6] = s52; obs[7] = s72;
         for (int i = 0; i < 8; i++) checkEq({tag, "_", names[i]}, obs[i], e.a[i]);
`ifdef FLIP_POS_OUT_EN
         checkEq({tag, "_pos1"}, pos1, e.p1);
         checkEq({tag, "_pos2"}, pos2, e.p2);
`endif
         checkBit({tag, "_valid"}, flipValid, 1'b1);
         checkBit({tag, "_busy"}, busy, 1'b0);
      end
   endtask

   task automatic fillRel(input int base);
      for (int i = 0; i < 1023; i++) relArr[i] = base;
   endtask

   initial begin
      rstN   = 1'b0;
      iCode  = 2'b00;
      iStart = 1'b0;
      iValid = 1'b0;
      iRel   = '0;
      repeat (3) @(negedge clk);
      checkBit("reset_valid", flipValid, 1'b0);
      checkBit("reset_busy", busy, 1'b0);
      checkEq("reset_S1_1", s11, 10'd0);
      checkEq("reset_S1_2", s12, 10'd0);
      rstN = 1'b1;

      // Beats while idle must not start a frame.
      iValid = 1'b1;
      repeat (4) @(negedge clk);
      iValid = 1'b0;
      checkBit("idle_ignore_busy", busy, 1'b0);
      checkBit("idle_ignore_valid", flipValid, 1'b0);

      $display("[TB] case 1: code 00, pos0=3 pos1=1");
      fillRel(10);
      relArr[0] = 3;
      relArr[1] = 1;
      applyStimulus(2'b00, 63, 1'b0, 1'b1);
      iValid = 1'b1;
      iRel   = '0;
      repeat (5) @(negedge clk);
      iValid = 1'b0;
      checkOutput("case1");

      $display("[TB] case 2: case 1 with gaps");
      applyStimulus(2'b00, 63, 1'b1, 1'b1);
      checkOutput("gaps");

      $display("[TB] case 3: code 10, pos1=0 pos2=1");
      fillRel(50);
      relArr[1] = 0;
      relArr[2] = 1;
      applyStimulus(2'b10, 1023, 1'b0, 1'b1);
      checkOutput("case2");

      $display("[TB] case 4: code 01, all ties");
      fillRel(5);
      applyStimulus(2'b01, 255, 1'b0, 1'b1);
      checkOutput("ties");

      $display("[TB] case 5: restart mid-scan");
      fillRel(10);
      relArr[5] = 0;
      relArr[7] = 0;
      applyStimulus(2'b00, 30, 1'b0, 1'b0);
      fillRel(10);
      relArr[40] = 2;
      relArr[50] = 4;
      applyStimulus(2'b00, 63, 1'b0, 1'b1);
      checkOutput("restart");

      $display("[TB] case 6: async reset mid-frame");
      fillRel(50);
      relArr[300] = 3;
      relArr[700] = 1;
      applyStimulus(2'b10, 101, 1'b0, 1'b0);
      #2 rstN = 1'b0;
      #1;
      checkBit("midreset_busy", busy, 1'b0);
      checkBit("midreset_valid", flipValid, 1'b0);
      checkEq("midreset_S1_1", s11, 10'd0);
      @(negedge clk);
      iValid = 1'b0;
      iStart = 1'b0;
      rstN   = 1'b1;
      checkBit("after_reset_busy", busy, 1'b0);
      fillRel(40);
      relArr[1000] = 2;
      relArr[1022] = 0;
      applyStimulus(2'b10, 1023, 1'b0, 1'b1);
      checkOutput("post_reset");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
